seg_display_arbiter: RTL and testbench

Arbitrates between several on-chip requesters that want to show a 32-bit value on the 8-digit seven-segment display and sequences the display driver. It issues single-cycle write strobes with registered data to the driver's enable/data inputs and produces the periodic digit-scan strobe. It sits between the MMIO/debug sources (CPU store port, PC monitor, etc.) and the LED driver.

---
 rtl/seg_display_arbiter.sv | 145 ++++++++++++++
 tb/tb_seg_display_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter feeding the 8-digit LED driver, plus free-running digit-scan strobe; SEG_ARB_DWELL_EN adds an owner dwell window.
// Write issues one cycle after a request is first seen in IDLE; losing requesters simply hold REQ until their ACK.
module seg_display_arbiter #(
   parameter int NREQ         = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int DWELL_CYCLES = 1000000
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [NREQ-1:0]         REQ,
   input  logic [32*NREQ-1:0]      REQ_DATA,
   output logic [NREQ-1:0]         ACK,
   output logic                    LED_EN,
   output logic [31:0]             LED_DATA,
   output logic                    SCAN_TICK,
   output logic [$clog2(NREQ)-1:0] OWNER,
   output logic                    BUSY
);

   localparam int IW = $clog2(NREQ);
   localparam int SW = $clog2(SCAN_DIV);

   if (NREQ < 2 || NREQ > 8 || SCAN_DIV < 2 || DWELL_CYCLES < 2) begin : g_param_check
      $error("seg_display_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE
`ifdef SEG_ARB_DWELL_EN
      , DWELL
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_nxt;
   logic [NREQ-1:0] req_rot;
   logic [IW:0]     rot_off, rot_sum;
   logic [IW-1:0]   grant_idx;
   logic            load_grant, load_owner;
   logic [IW-1:0]   sel_idx;
   logic [31:0]     sel_data;
   logic [SW-1:0]   scan_q;

`ifdef SEG_ARB_DWELL_EN
   localparam int DW = $clog2(DWELL_CYCLES + 1);
   logic [DW-1:0]   dwell_q;
`endif

   // Rotate so bit 0 is the pointer position, take the lowest set bit, rotate back.
   always_comb begin
      req_rot = NREQ'({REQ, REQ} >> ptr_q);
      rot_off = '0;
      for (int k = NREQ - 1; k >= 0; k--)
         if (req_rot[k]) rot_off = (IW+1)'(k);
      rot_sum   = rot_off + {1'b0, ptr_q};
      grant_idx = (rot_sum >= (IW+1)'(NREQ)) ? IW'(rot_sum - (IW+1)'(NREQ)) : IW'(rot_sum);
      ptr_nxt   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      load_grant = 1'b0;
      load_owner = 1'b0;
      case (state_q)
         IDLE: begin
            if (|REQ) begin
               state_d    = ISSUE;
               load_grant = 1'b1;
            end
         end
`ifdef SEG_ARB_DWELL_EN
         // The counter also ticks during ISSUE, so an ISSUE that drains it ends the tenure.
         ISSUE: state_d = (dwell_q <= DW'(1)) ? IDLE : DWELL;
         DWELL: begin
            if (dwell_q == '0) begin
               state_d = IDLE;
            end else if (REQ[OWNER]) begin
               state_d    = ISSUE;
               load_owner = 1'b1;
            end
         end
`else
         ISSUE: state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_idx  = load_owner ? OWNER : grant_idx;
      sel_data = REQ_DATA[31:0];
      for (int i = 1; i < NREQ; i++)
         if (sel_idx == IW'(i)) sel_data = REQ_DATA[32*i +: 32];
   end

   always_comb begin
      ACK    = '0;
      LED_EN = (state_q == ISSUE);
      BUSY   = (state_q != IDLE);
      if (state_q == ISSUE) ACK[OWNER] = 1'b1;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         OWNER    <= '0;
         LED_DATA <= 32'h8888_8888;
      end else begin
         state_q <= state_d;
         if (load_grant) begin
            OWNER    <= grant_idx;
            LED_DATA <= sel_data;
            ptr_q    <= ptr_nxt;
         end else if (load_owner) begin
            LED_DATA <= sel_data;
         end
      end
   end

`ifdef SEG_ARB_DWELL_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dwell_q <= '0;
      end else if (load_grant) begin
         dwell_q <= DW'(DWELL_CYCLES);
      end else if (state_q != IDLE && dwell_q != '0) begin
         dwell_q <= dwell_q - 1'b1;
      end
   end
`endif

   // Tick is registered off the count that precedes the terminal value, so it aligns with count == SCAN_DIV-1.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         scan_q    <= '0;
         SCAN_TICK <= 1'b0;
      end else begin
         scan_q    <= (scan_q == SW'(SCAN_DIV - 1)) ? '0 : scan_q + 1'b1;
         SCAN_TICK <= (scan_q == SW'(SCAN_DIV - 2));
      end
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: stimulus queues expected writes, a negedge monitor checks them.
module tb_seg_display_arbiter;
   localparam int NREQ         = 4;
   localparam int SCAN_DIV     = 4;
   localparam int DWELL_CYCLES = 8;
`ifdef SEG_ARB_DWELL_EN
   localparam int SPC = DWELL_CYCLES + 2;
`else
   localparam int SPC = 2;
`endif

   logic                   clk      = 1'b0;
   logic                   rst      = 1'b1;
   logic [NREQ-1:0]        req      = '0;
   logic [32*NREQ-1:0]     req_data = '0;
   logic [NREQ-1:0]        ack;
   logic                   led_en;
   logic [31:0]            led_data;
   logic                   scan_tick;
   logic [1:0]             owner;
   logic                   busy;

   seg_display_arbiter #(
      .NREQ(NREQ), .SCAN_DIV(SCAN_DIV), .DWELL_CYCLES(DWELL_CYCLES)
   ) dut (
      .CLK(clk), .RESET(rst), .REQ(req), .REQ_DATA(req_data), .ACK(ack),
      .LED_EN(led_en), .LED_DATA(led_data), .SCAN_TICK(scan_tick), .OWNER(owner), .BUSY(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NREQ-1:0] ack;
      logic [31:0]     data;
      logic [1:0]      owner;
      int              cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          cyc   = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_data  = 32'h8888_8888;
   logic [1:0]  last_owner = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Monitor: cycle 1 is the first cycle with reset released.
   always @(negedge clk) begin
      if (rst) begin
         cyc        = 0;
         last_data  = 32'h8888_8888;
         last_owner = '0;
         chk("rst_led_en", 32'(led_en), 32'd0);
         chk("rst_ack", 32'(ack), 32'd0);
         chk("rst_led_data", led_data, 32'h8888_8888);
         chk("rst_owner", 32'(owner), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_scan_tick", 32'(scan_tick), 32'd0);
      end else begin
         cyc = cyc + 1;
         chk("scan_tick", 32'(scan_tick), 32'((cyc % SCAN_DIV) == 0));
         if (led_en) begin
            chk("busy_issue", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 32'(led_en), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("ack", 32'(ack), 32'(mon_e.ack));
               chk("led_data", led_data, mon_e.data);
               chk("owner", 32'(owner), 32'(mon_e.owner));
               chk("ack_cycle", cyc, mon_e.cyc);
               last_data  = mon_e.data;
               last_owner = mon_e.owner;
            end
         end else begin
            chk("ack_quiet", 32'(ack), 32'd0);
            chk("led_data_hold", led_data, last_data);
            chk("owner_hold", 32'(owner), 32'(last_owner));
`ifndef SEG_ARB_DWELL_EN
            chk("busy_idle", 32'(busy), 32'd0);
`endif
            if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
               chk("ack_timeout", cyc, exp_q[0].cyc);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   function automatic int now();
      return cyc + 1;
   endfunction

   // Advance one cycle; requesters drop REQ while their ACK is showing.
   task automatic step();
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++)
         if (ack[i]) req[i] = 1'b0;
   endtask

   task automatic expect_wr(input int idx, input logic [31:0] d, input int at);
      exp_t e;
      e.ack      = '0;
      e.ack[idx] = 1'b1;
      e.data     = d;
      e.owner    = 2'(idx);
      e.cyc      = at;
      exp_q.push_back(e);
   endtask

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      step();

      // All four request at once: served 0,1,2,3.
      req_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      c   = now();
      req = 4'b1111;
      expect_wr(0, 32'h1111_1111, c + 1);
      expect_wr(1, 32'h2222_2222, c + 1 + SPC);
      expect_wr(2, 32'h3333_3333, c + 1 + 2*SPC);
      expect_wr(3, 32'h4444_4444, c + 1 + 3*SPC);
      repeat (4*SPC) step();

      // Pointer wrapped to 0: requester 0 before 3.
      c   = now();
      req = 4'b1001;
      expect_wr(0, 32'h1111_1111, c + 1);
      expect_wr(3, 32'h4444_4444, c + 1 + SPC);
      repeat (2*SPC) step();

      c = now();
      req_data[95:64] = 32'h1234_5678;
      req = 4'b0100;
      expect_wr(2, 32'h1234_5678, c + 1);
      repeat (SPC + 3) step();

`ifdef SEG_ARB_DWELL_EN
      // Owner fast path during dwell; requester 1 waits for expiry.
      c = now();
      req_data[31:0] = 32'hA0A0_A0A0;
      req = 4'b0001;
      expect_wr(0, 32'hA0A0_A0A0, c + 1);
      step();
      step();
      req_data[63:32] = 32'hB1B1_B1B1;
      req[1] = 1'b1;
      step();
      step();
      req_data[31:0] = 32'hC0C0_C0C0;
      req[0] = 1'b1;
      expect_wr(0, 32'hC0C0_C0C0, c + 5);
      expect_wr(1, 32'hB1B1_B1B1, c + 11);
      repeat (16) step();

      // Owner re-requests in the expiry cycle: requester 1 goes first.
      c = now();
      req_data[31:0] = 32'hD0D0_D0D0;
      req = 4'b0001;
      expect_wr(0, 32'hD0D0_D0D0, c + 1);
      repeat (9) step();
      req_data[63:32] = 32'hE1E1_E1E1;
      req = 4'b0011;
      expect_wr(1, 32'hE1E1_E1E1, c + 11);
      expect_wr(0, 32'hD0D0_D0D0, c + 21);
      repeat (30) step();
`endif

      // Reset shortly after a write: outputs return to reset values immediately.
      c = now();
      req_data[95:64] = 32'hDEAD_BEEF;
      req = 4'b0100;
      expect_wr(2, 32'hDEAD_BEEF, c + 1);
      step();
      step();
      rst = 1'b1;
      req = '0;
      step();
      step();
      rst = 1'b0;
      step();

      // Pointer must be back at 0 after reset.
      c = now();
      req_data[31:0]   = 32'h5A5A_5A5A;
      req_data[127:96] = 32'hA5A5_A5A5;
      req = 4'b1001;
      expect_wr(0, 32'h5A5A_5A5A, c + 1);
      expect_wr(3, 32'hA5A5_A5A5, c + 1 + SPC);
      repeat (2*SPC + 2) step();

      for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
